mesh_inject_arb: RTL and testbench



---
 rtl/mesh_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mesh_inject_arb.sv | 132 +++++++++++++
 tb/tb_mesh_inject_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared mesh definitions: flit width, default packet length and the
// injection FSM state encoding.
package mesh_pkg;

    localparam int unsigned FLIT_WIDTH = 4;
    localparam int unsigned PKT_FLITS  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } inject_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// scanning upward with wrap. Reused by every mesh boundary injector.
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                valid
);

    int unsigned sel;

    // Upper pass covers [ptr, NUM_REQ), lower pass handles the wrap.
    always_comb begin
        sel   = 0;
        valid = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!valid && req[j] && (j >= 32'(ptr))) begin
                sel   = j;
                valid = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!valid && req[j]) begin
                sel   = j;
                valid = 1'b1;
            end
        end
        grant    = valid ? (NUM_REQ'(1) << sel) : '0;
        grant_id = ID_WIDTH'(sel);
    end

endmodule

// File: rtl/mesh_inject_arb.sv
// Packet-locked round-robin injector sharing one mesh boundary input port
// among NUM_REQ spike sources, with back-pressure from the cell's full flag.
module mesh_inject_arb #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned FLIT_WIDTH   = mesh_pkg::FLIT_WIDTH,
    parameter int unsigned PKT_FLITS    = mesh_pkg::PKT_FLITS,
    parameter int unsigned REQ_ID_WIDTH = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] flit_in,
    output logic [NUM_REQ-1:0]            flit_ack,
    input  logic                          port_full,
    output logic [FLIT_WIDTH-1:0]         port_data,
    output logic                          port_en,
    output logic [REQ_ID_WIDTH-1:0]       grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pkt_cnt
);

    import mesh_pkg::*;

    localparam int unsigned FCNT_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
    localparam logic [FCNT_W-1:0]       LAST_FLIT = FCNT_W'(PKT_FLITS - 1);
    localparam logic [REQ_ID_WIDTH-1:0] LAST_REQ  = REQ_ID_WIDTH'(NUM_REQ - 1);

    inject_state_t             state, state_nxt;
    logic [REQ_ID_WIDTH-1:0]   grant_id_nxt;
    logic [NUM_REQ-1:0]        grant_oh, grant_oh_nxt;
    logic [REQ_ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic [FCNT_W-1:0]         flit_cnt, flit_cnt_nxt;
    logic [FLIT_WIDTH-1:0]     port_data_nxt;
    logic                      port_en_nxt;
    logic [CNT_WIDTH-1:0]      pkt_cnt_nxt;

    logic [NUM_REQ-1:0]        arb_grant;
    logic [REQ_ID_WIDTH-1:0]   arb_id;
    logic                      arb_valid;
    logic [FLIT_WIDTH-1:0]     sel_flit;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (REQ_ID_WIDTH)
    ) u_rr_arbiter (
        .req      (req),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .valid    (arb_valid)
    );

    // One-hot AND-OR mux of the owner's head flit.
    always_comb begin
        sel_flit = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_flit = sel_flit | flit_in[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= '0;
            grant_oh  <= '0;
            rr_ptr    <= '0;
            flit_cnt  <= '0;
            port_data <= '0;
            port_en   <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_id_nxt;
            grant_oh  <= grant_oh_nxt;
            rr_ptr    <= rr_ptr_nxt;
            flit_cnt  <= flit_cnt_nxt;
            port_data <= port_data_nxt;
            port_en   <= port_en_nxt;
            pkt_cnt   <= pkt_cnt_nxt;
        end
    end

    // Port stays locked to one requester until its last flit is captured.
    always_comb begin
        state_nxt     = state;
        grant_id_nxt  = grant_id;
        grant_oh_nxt  = grant_oh;
        rr_ptr_nxt    = rr_ptr;
        flit_cnt_nxt  = flit_cnt;
        port_data_nxt = port_data;
        port_en_nxt   = 1'b0;
        pkt_cnt_nxt   = pkt_cnt;
        flit_ack      = '0;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_id_nxt = arb_id;
                    grant_oh_nxt = arb_grant;
                    flit_cnt_nxt = '0;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (!port_full) begin
                    port_data_nxt = sel_flit;
                    port_en_nxt   = 1'b1;
                    flit_ack      = grant_oh;
                    flit_cnt_nxt  = flit_cnt + FCNT_W'(1);
                    if (flit_cnt == LAST_FLIT) begin
                        state_nxt   = GAP;
                        pkt_cnt_nxt = pkt_cnt + CNT_WIDTH'(1);
                        rr_ptr_nxt  = (grant_id == LAST_REQ) ? '0
                                                             : grant_id + REQ_ID_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mesh_inject_arb.sv
// Directed bench for mesh_inject_arb: behavioural requesters feed packets,
// a scoreboard queue predicts the flit/owner sequence seen at the port.
module tb_mesh_inject_arb;

    localparam int unsigned NR = 4;
    localparam int unsigned FW = 4;
    localparam int unsigned PF = 2;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req;
    logic [NR*FW-1:0] flit_in;
    logic             port_full;
    logic [NR-1:0]    flit_ack, flit_ack2;
    logic [FW-1:0]    port_data, port_data2;
    logic             port_en, port_en2;
    logic [IW-1:0]    grant_id, grant_id2;
    logic             busy, busy2;
    logic [15:0]      pkt_cnt;
    logic [1:0]       pkt_cnt2;

    mesh_inject_arb #(.NUM_REQ(NR), .FLIT_WIDTH(FW), .PKT_FLITS(PF),
                      .REQ_ID_WIDTH(IW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .flit_in(flit_in),
        .flit_ack(flit_ack), .port_full(port_full), .port_data(port_data),
        .port_en(port_en), .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    mesh_inject_arb #(.NUM_REQ(NR), .FLIT_WIDTH(FW), .PKT_FLITS(PF),
                      .REQ_ID_WIDTH(IW), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .flit_in(flit_in),
        .flit_ack(flit_ack2), .port_full(port_full), .port_data(port_data2),
        .port_en(port_en2), .grant_id(grant_id2), .busy(busy2), .pkt_cnt(pkt_cnt2)
    );

    // Requester model: flit memory per source, popped on flit_ack.
    logic [FW-1:0] src_mem [NR][64];
    int unsigned   rd_ptr [NR];
    int unsigned   wr_ptr [NR];
    logic          src_clr;

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (src_clr)          rd_ptr[i] <= wr_ptr[i];
            else if (flit_ack[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            flit_in[i*FW +: FW] = src_mem[i][rd_ptr[i] % 64];
            req[i] = ((wr_ptr[i] - (rd_ptr[i] & ~32'd1)) >= PF);
        end
    end

    typedef struct packed {
        logic [IW-1:0] id;
        logic [FW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_pkt(input int unsigned i, input logic [FW-1:0] f0, input logic [FW-1:0] f1);
        src_mem[i][wr_ptr[i]]     = f0;
        src_mem[i][wr_ptr[i] + 1] = f1;
        wr_ptr[i] = wr_ptr[i] + 2;
        exp_q.push_back({IW'(i), f0});
        exp_q.push_back({IW'(i), f1});
    endtask

    // Advance one clock and check whatever the port emitted.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        chk("ack_onehot", 32'($onehot0(flit_ack)), 32'd1);
        chk("ack_only_busy", 32'((flit_ack == '0) || busy), 32'd1);
        if (port_en) begin
            chk("flit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("port_data", 32'(port_data), 32'(e.data));
                chk("owner_id", 32'(grant_id), 32'(e.id));
                chk("dut2_en", 32'(port_en2), 32'd1);
                chk("dut2_data", 32'(port_data2), 32'(e.data));
            end
        end
    endtask

    task automatic run_until_done(input string tag, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || busy || req != '0) && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < bound), 32'd1);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        src_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n   = 1'b1;
        src_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        port_full = 1'b0;
        src_clr   = 1'b1;
        rst_n     = 1'b0;
        for (int i = 0; i < NR; i++) begin
            wr_ptr[i] = 0;
            for (int k = 0; k < 64; k++) src_mem[i][k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_port_en", 32'(port_en), 32'd0);
        chk("rst_port_data", 32'(port_data), 32'd0);
        chk("rst_flit_ack", 32'(flit_ack), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_pkt_cnt2", 32'(pkt_cnt2), 32'd0);
        rst_n   = 1'b1;
        src_clr = 1'b0;
        tick();

        // Single packet from requester 0, cycle by cycle.
        push_pkt(0, 4'h3, 4'h5);
        tick();
        chk("t1_busy_send", 32'(busy), 32'd1);
        chk("t1_ack_first", 32'(flit_ack), 32'h1);
        chk("t1_en_low", 32'(port_en), 32'd0);
        chk("t1_grant", 32'(grant_id), 32'd0);
        tick();
        chk("t1_en_first", 32'(port_en), 32'd1);
        chk("t1_ack_second", 32'(flit_ack), 32'h1);
        tick();
        chk("t1_en_second", 32'(port_en), 32'd1);
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("t1_busy_gap", 32'(busy), 32'd1);
        chk("t1_ack_gap", 32'(flit_ack), 32'd0);
        tick();
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_en_idle", 32'(port_en), 32'd0);
        chk("t1_acks", rd_ptr[0], 32'd2);

        // All four request together: 0,1,2,3 from a fresh pointer.
        do_reset();
        push_pkt(0, 4'h0, 4'hC);
        push_pkt(1, 4'h1, 4'hD);
        push_pkt(2, 4'h2, 4'hE);
        push_pkt(3, 4'h3, 4'hF);
        run_until_done("t2_drain", 60);
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd4);
        chk("t2_pkt_cnt2", 32'(pkt_cnt2), 32'd0);

        // Back-pressure after the first flit; packet must not be split.
        push_pkt(0, 4'h9, 4'hA);
        push_pkt(1, 4'h6, 4'h7);
        tick();
        chk("t3_grant", 32'(grant_id), 32'd0);
        tick();
        port_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_stall_en", 32'(port_en), 32'd0);
            chk("t3_stall_ack", 32'(flit_ack), 32'd0);
            chk("t3_stall_grant", 32'(grant_id), 32'd0);
        end
        port_full = 1'b0;
        #1;
        chk("t3_resume_ack", 32'(flit_ack), 32'h1);
        tick();
        chk("t3_resume_en", 32'(port_en), 32'd1);
        tick();
        chk("t3_gap_en", 32'(port_en), 32'd0);
        run_until_done("t3_drain", 40);
        chk("t3_pkt_cnt", 32'(pkt_cnt), 32'd6);

        // Move pointer to 3, then requests 0 and 2: wrap to 0 first.
        push_pkt(2, 4'h1, 4'h2);
        run_until_done("t4_pre_drain", 20);
        push_pkt(0, 4'h4, 4'h8);
        push_pkt(2, 4'hB, 4'hE);
        tick();
        chk("t4_wrap_grant", 32'(grant_id), 32'd0);
        run_until_done("t4_drain", 40);
        chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd9);

        // Reset in the middle of a packet from requester 3.
        push_pkt(3, 4'hD, 4'hE);
        tick();
        chk("t5_grant", 32'(grant_id), 32'd3);
        tick();
        rst_n   = 1'b0;
        src_clr = 1'b1;
        #1;
        chk("t5_rst_en", 32'(port_en), 32'd0);
        chk("t5_rst_grant", 32'(grant_id), 32'd0);
        chk("t5_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ack", 32'(flit_ack), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("t5_rst_ack_held", 32'(flit_ack), 32'd0);
        chk("t5_rst_busy2", 32'(busy2), 32'd0);
        chk("t5_rst_grant2", 32'(grant_id2), 32'd0);
        rst_n   = 1'b1;
        src_clr = 1'b0;
        push_pkt(1, 4'h7, 4'h1);
        tick();
        chk("t5_first_grant", 32'(grant_id), 32'd1);
        run_until_done("t5_drain", 20);
        chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Four more packets: pointer now 2, so order 2,3,0,1; narrow counter wraps.
        push_pkt(2, 4'h5, 4'hA);
        push_pkt(3, 4'h6, 4'h9);
        push_pkt(0, 4'hF, 4'h0);
        push_pkt(1, 4'h8, 4'h4);
        run_until_done("t6_drain", 60);
        chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd5);
        chk("t6_pkt_cnt2_wrap", 32'(pkt_cnt2), 32'd1);
        chk("t6_flit_ack2_idle", 32'(flit_ack2), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
